// File: rtl/npu_core_ctrl.sv
// -----------------------------------------------------------------------------
// npu_core_ctrl
//
// Job sequencer for the NPU systolic core. A job produces cfg_pixels output
// pixels, each accumulated over cfg_ic_passes operand beats. The controller
// accepts beats from the operand buffers, marks the first pass of each pixel
// as bias-carrying, and sends "first pass" / "last pass" tags down delay lines
// that line up with the array latency. The delayed tags then strobe the
// accumulator load (adder_rst) and flag finished pixels (out_valid).
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   start, abort         job launch (IDLE only) / synchronous cancel
//   cfg_ic_passes        beats per pixel (0 is treated as 1), latched on start
//   cfg_pixels           pixels per job, latched on start
//   cfg_scale            output right-shift, latched on start
//   src_valid/src_ready  operand beat handshake (beat = valid & ready)
//   npu_data_valid       operands live this cycle
//   npu_bias_en          bias live this cycle (first pass of a pixel)
//   npu_scale            latched scale for the job
//   adder_rst            accumulator load strobe, all lanes identical
//   out_valid            finished pixel at the NPU output
//   out_pixel_idx        index of that pixel
//   busy, done           not-IDLE flag / one-cycle completion pulse
// -----------------------------------------------------------------------------
module npu_core_ctrl #(
    parameter int NPU_OUT_NUM   = 18,
    parameter int ARRAY_LATENCY = 11,
    parameter int POST_LATENCY  = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [7:0]             cfg_ic_passes,
    input  logic [15:0]            cfg_pixels,
    input  logic [3:0]             cfg_scale,
    input  logic                   src_valid,
    output logic                   src_ready,
    output logic                   npu_data_valid,
    output logic                   npu_bias_en,
    output logic [3:0]             npu_scale,
    output logic [NPU_OUT_NUM-1:0] adder_rst,
    output logic                   out_valid,
    output logic [15:0]            out_pixel_idx,
    output logic                   busy,
    output logic                   done
);

    localparam int OUT_LATENCY = ARRAY_LATENCY + POST_LATENCY;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Latched job configuration; passes_q already holds the effective count.
    logic [7:0]  passes_q;
    logic [15:0] pixels_q;
    logic [3:0]  scale_q;

    logic [7:0]  pass_cnt_q;
    logic [15:0] pix_cnt_q;

    logic beat;
    logic first_pass;
    logic last_pass;
    logic last_pix;
    logic start_acc;

    // Tag delay lines: bit 0 is the tag of the beat one cycle ago.
    logic [ARRAY_LATENCY-1:0] rst_line_q;
    logic [OUT_LATENCY-1:0]   ov_line_q;
    logic [OUT_LATENCY-1:0]   fin_line_q;

    assign start_acc  = (state_q == IDLE) && start && !abort;
    assign src_ready  = (state_q == RUN);
    assign beat       = src_valid & src_ready;
    assign first_pass = (pass_cnt_q == 8'd0);
    assign last_pass  = (pass_cnt_q == passes_q - 8'd1);
    assign last_pix   = (pix_cnt_q == pixels_q - 16'd1);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (cfg_pixels == 16'd0) ? DONE : RUN;
            RUN:     if (beat && last_pass && last_pix) state_d = DRAIN;
            // fin_line_q marks the out_valid belonging to the job's last pixel
            DRAIN:   if (out_valid && fin_line_q[OUT_LATENCY-1]) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    // ---------------- config latch and pass/pixel counters ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            passes_q   <= '0;
            pixels_q   <= '0;
            scale_q    <= '0;
            pass_cnt_q <= '0;
            pix_cnt_q  <= '0;
        end else if (abort) begin
            pass_cnt_q <= '0;
            pix_cnt_q  <= '0;
        end else if (start_acc) begin
            passes_q   <= (cfg_ic_passes == 8'd0) ? 8'd1 : cfg_ic_passes;
            pixels_q   <= cfg_pixels;
            scale_q    <= cfg_scale;
            pass_cnt_q <= '0;
            pix_cnt_q  <= '0;
        end else if (beat) begin
            if (last_pass) begin
                pass_cnt_q <= '0;
                pix_cnt_q  <= pix_cnt_q + 16'd1;
            end else begin
                pass_cnt_q <= pass_cnt_q + 8'd1;
            end
        end
    end

    // ---------------- tag delay lines ----------------
    // Each beat pushes its own tags, so overlapping pixels never interfere.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_line_q <= '0;
            ov_line_q  <= '0;
            fin_line_q <= '0;
        end else if (abort) begin
            rst_line_q <= '0;
            ov_line_q  <= '0;
            fin_line_q <= '0;
        end else begin
            rst_line_q <= {rst_line_q[ARRAY_LATENCY-2:0], beat & first_pass};
            ov_line_q  <= {ov_line_q[OUT_LATENCY-2:0], beat & last_pass};
            fin_line_q <= {fin_line_q[OUT_LATENCY-2:0], beat & last_pass & last_pix};
        end
    end

    // Pixel index travels alongside the out_valid tag, one register per stage.
    genvar gi;
    generate
        for (gi = 0; gi < OUT_LATENCY; gi++) begin : g_idx
            logic [15:0] idx_q;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        idx_q <= '0;
                    end else if (abort) begin
                        idx_q <= '0;
                    end else begin
                        idx_q <= pix_cnt_q;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        idx_q <= '0;
                    end else if (abort) begin
                        idx_q <= '0;
                    end else begin
                        idx_q <= g_idx[gi-1].idx_q;
                    end
                end
            end
        end
    endgenerate

    // ---------------- outputs ----------------
    assign npu_data_valid = beat;
    assign npu_bias_en    = beat & first_pass;
    assign npu_scale      = scale_q;
    assign adder_rst      = {NPU_OUT_NUM{rst_line_q[ARRAY_LATENCY-1]}};
    assign out_valid      = ov_line_q[OUT_LATENCY-1];
    assign out_pixel_idx  = g_idx[OUT_LATENCY-1].idx_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);

endmodule

// File: tb/tb_npu_core_ctrl.sv
// -----------------------------------------------------------------------------
// tb_npu_core_ctrl
//
// Drives jobs into npu_core_ctrl and compares the timeline of events it
// produces (beats, bias, accumulator loads, finished pixels, done, busy
// cycles) against either literal expectations or a job-level model that
// derives event times from beat order: pass = k % passes, pixel = k / passes.
// Event times are printed as cycle offsets from the cycle start was high.
// -----------------------------------------------------------------------------
module tb_npu_core_ctrl;

    localparam int NOUT = 18;
    localparam int AL   = 11;
    localparam int PL   = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [7:0]        cfg_ic_passes = '0;
    logic [15:0]       cfg_pixels = '0;
    logic [3:0]        cfg_scale = '0;
    logic              src_valid = 1'b0;
    logic              src_ready;
    logic              npu_data_valid;
    logic              npu_bias_en;
    logic [3:0]        npu_scale;
    logic [NOUT-1:0]   adder_rst;
    logic              out_valid;
    logic [15:0]       out_pixel_idx;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int job_s = 0;
    bit mon_en = 1'b0;

    string obs_beat, obs_bias, obs_rst, obs_ov, obs_done;
    int    obs_busy, obs_bad;
    string exp_beat, exp_bias, exp_rst, exp_ov, exp_done;
    int    exp_busy;

    npu_core_ctrl #(
        .NPU_OUT_NUM   (NOUT),
        .ARRAY_LATENCY (AL),
        .POST_LATENCY  (PL)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .abort          (abort),
        .cfg_ic_passes  (cfg_ic_passes),
        .cfg_pixels     (cfg_pixels),
        .cfg_scale      (cfg_scale),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .npu_data_valid (npu_data_valid),
        .npu_bias_en    (npu_bias_en),
        .npu_scale      (npu_scale),
        .adder_rst      (adder_rst),
        .out_valid      (out_valid),
        .out_pixel_idx  (out_pixel_idx),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled mid-cycle. Cleared at offset 0 of each job.
    always @(negedge clk) begin
        int o;
        if (mon_en) begin
            o = cyc - job_s;
            if (o == 0) begin
                obs_beat = ""; obs_bias = ""; obs_rst = ""; obs_ov = ""; obs_done = "";
                obs_busy = 0; obs_bad = 0;
            end
            if (npu_data_valid) obs_beat = {obs_beat, $sformatf("%0d,", o)};
            if (npu_bias_en) obs_bias = {obs_bias, $sformatf("%0d,", o)};
            if (adder_rst != '0) obs_rst = {obs_rst, (adder_rst === '1) ? $sformatf("%0d,", o) : $sformatf("%0dP,", o)};
            if (out_valid) obs_ov = {obs_ov, $sformatf("%0d:%0d,", o, out_pixel_idx)};
            if (done) obs_done = {obs_done, $sformatf("%0d,", o)};
            if (busy) obs_busy++;
            if (npu_data_valid !== (src_valid & src_ready)) obs_bad++;
            if (npu_bias_en && !npu_data_valid) obs_bad++;
        end
    end

    // Runs one job (start at offset 0) and builds the model expectations.
    // st_lo..st_hi: offsets with src_valid forced low; ab_off: abort offset;
    // alt_off: offset of an extra start with different config (-1 = none).
    task automatic run_job(input int p, input int n, input int sc, input int pct,
                           input int st_lo, input int st_hi, input int ab_off, input int alt_off);
        int  pe, total, k, q_done, end_off;
        bit  aborted;
        int  q_rst[$], q_ovc[$], q_ovi[$], k_c[$], k_i[$];
        pe = (p == 0) ? 1 : p;
        total = pe * n;
        k = 0; aborted = 1'b0; q_done = -1; end_off = 0;
        exp_beat = ""; exp_bias = "";
        @(posedge clk); #1;
        job_s = cyc;
        mon_en = 1'b1;
        for (int o = 0; o < 600; o++) begin
            if (o > 0) begin @(posedge clk); #1; end
            start = (o == 0) || (o == alt_off);
            abort = (o == ab_off);
            if (o == 0) begin
                cfg_ic_passes = 8'(p); cfg_pixels = 16'(n); cfg_scale = 4'(sc);
            end else if (o == alt_off) begin
                cfg_ic_passes = 8'(p + 3); cfg_pixels = 16'(n + 4); cfg_scale = 4'(~sc);
            end else begin
                cfg_ic_passes = 8'($urandom); cfg_pixels = 16'($urandom); cfg_scale = 4'($urandom);
            end
            src_valid = !(o >= st_lo && o <= st_hi) && ($urandom_range(1, 100) <= pct);
            if (!aborted && n > 0 && o >= 1 && k < total && src_valid) begin
                exp_beat = {exp_beat, $sformatf("%0d,", o)};
                if (k % pe == 0) begin
                    exp_bias = {exp_bias, $sformatf("%0d,", o)};
                    q_rst.push_back(o + AL);
                end
                if (k % pe == pe - 1) begin
                    q_ovc.push_back(o + AL + PL);
                    q_ovi.push_back(k / pe);
                end
                k++;
                if (k == total) q_done = o + AL + PL + 1;
            end
            if (n == 0 && o == 0) q_done = 1;
            // an abort only matters while the job is still in progress
            if (o == ab_off && !aborted && (q_done < 0 || o < q_done)) begin
                aborted = 1'b1;
                k_c = {};
                foreach (q_rst[i]) if (q_rst[i] <= o) k_c.push_back(q_rst[i]);
                q_rst = k_c;
                k_c = {}; k_i = {};
                foreach (q_ovc[i]) if (q_ovc[i] <= o) begin k_c.push_back(q_ovc[i]); k_i.push_back(q_ovi[i]); end
                q_ovc = k_c; q_ovi = k_i;
                if (q_done > o) q_done = -1;
            end
            end_off = aborted ? ab_off : q_done;
            if ((aborted || q_done >= 0) && o >= end_off + AL + PL + 3) break;
        end
        mon_en = 1'b0;
        start = 1'b0; abort = 1'b0; src_valid = 1'b0;
        exp_rst = "";
        foreach (q_rst[i]) exp_rst = {exp_rst, $sformatf("%0d,", q_rst[i])};
        exp_ov = "";
        foreach (q_ovc[i]) exp_ov = {exp_ov, $sformatf("%0d:%0d,", q_ovc[i], q_ovi[i])};
        exp_done = (q_done >= 0) ? $sformatf("%0d,", q_done) : "";
        exp_busy = aborted ? ab_off : ((q_done >= 0) ? q_done : 0);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({src_ready, npu_data_valid, npu_bias_en, npu_scale, adder_rst, out_valid, out_pixel_idx, busy, done} !== '0) begin errors++; $display("FAIL reset_outputs got=%h want=0", {src_ready, npu_data_valid, npu_bias_en, npu_scale, adder_rst, out_valid, out_pixel_idx, busy, done}); end
        rstn = 1'b1;
        @(posedge clk); #1;
        job_s = cyc; mon_en = 1'b1;
        start = 1'b1; cfg_ic_passes = 8'd2; cfg_pixels = 16'd3; cfg_scale = 4'd9; src_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (npu_scale !== 4'd9) begin errors++; $display("FAIL reset_prejob_scale got=%0d want=9", npu_scale); end
        rstn = 1'b0;
        #1;
        checks++; if ({src_ready, npu_data_valid, npu_bias_en, npu_scale, adder_rst, out_valid, out_pixel_idx, busy, done} !== '0) begin errors++; $display("FAIL reset_midjob_outputs got=%h want=0", {src_ready, npu_data_valid, npu_bias_en, npu_scale, adder_rst, out_valid, out_pixel_idx, busy, done}); end
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        mon_en = 1'b0; src_valid = 1'b0;
        checks++; if (obs_beat != "1,2,3,4,5,") begin errors++; $display("FAIL reset_beats got=%s want=%s", obs_beat, "1,2,3,4,5,"); end
        checks++; if ({obs_rst, obs_ov, obs_done} != "") begin errors++; $display("FAIL reset_no_events got=%s|%s|%s want=empty", obs_rst, obs_ov, obs_done); end
    endtask

    task automatic test_basic();
        run_job(3, 2, 6, 100, -1, -1, -1, -1);
        checks++; if (obs_beat != "1,2,3,4,5,6,") begin errors++; $display("FAIL basic_beats got=%s want=%s", obs_beat, "1,2,3,4,5,6,"); end
        checks++; if (obs_bias != "1,4,") begin errors++; $display("FAIL basic_bias got=%s want=%s", obs_bias, "1,4,"); end
        checks++; if (obs_rst != "12,15,") begin errors++; $display("FAIL basic_rst got=%s want=%s", obs_rst, "12,15,"); end
        checks++; if (obs_ov != "18:0,21:1,") begin errors++; $display("FAIL basic_out got=%s want=%s", obs_ov, "18:0,21:1,"); end
        checks++; if (obs_done != "22,") begin errors++; $display("FAIL basic_done got=%s want=%s", obs_done, "22,"); end
        checks++; if (obs_busy !== 22) begin errors++; $display("FAIL basic_busy got=%0d want=22", obs_busy); end
        checks++; if (npu_scale !== 4'd6) begin errors++; $display("FAIL basic_scale got=%0d want=6", npu_scale); end
    endtask

    task automatic test_stall();
        run_job(3, 1, 0, 100, 2, 3, -1, -1);
        checks++; if (obs_beat != "1,4,5,") begin errors++; $display("FAIL stall_beats got=%s want=%s", obs_beat, "1,4,5,"); end
        checks++; if (obs_bias != "1,") begin errors++; $display("FAIL stall_bias got=%s want=%s", obs_bias, "1,"); end
        checks++; if (obs_rst != "12,") begin errors++; $display("FAIL stall_rst got=%s want=%s", obs_rst, "12,"); end
        checks++; if (obs_ov != "20:0,") begin errors++; $display("FAIL stall_out got=%s want=%s", obs_ov, "20:0,"); end
        checks++; if (obs_done != "21,") begin errors++; $display("FAIL stall_done got=%s want=%s", obs_done, "21,"); end
    endtask

    task automatic test_single_pass();
        run_job(1, 4, 3, 100, -1, -1, -1, -1);
        checks++; if (obs_bias != "1,2,3,4,") begin errors++; $display("FAIL single_bias got=%s want=%s", obs_bias, "1,2,3,4,"); end
        checks++; if (obs_rst != "12,13,14,15,") begin errors++; $display("FAIL single_rst got=%s want=%s", obs_rst, "12,13,14,15,"); end
        checks++; if (obs_ov != "16:0,17:1,18:2,19:3,") begin errors++; $display("FAIL single_out got=%s want=%s", obs_ov, "16:0,17:1,18:2,19:3,"); end
        checks++; if (obs_done != "20,") begin errors++; $display("FAIL single_done got=%s want=%s", obs_done, "20,"); end
    endtask

    task automatic test_zero_cfg();
        run_job(0, 0, 1, 100, -1, -1, -1, -1);
        checks++; if (obs_beat != "") begin errors++; $display("FAIL zero_pix_beats got=%s want=empty", obs_beat); end
        checks++; if (obs_done != "1,") begin errors++; $display("FAIL zero_pix_done got=%s want=%s", obs_done, "1,"); end
        checks++; if (obs_busy !== 1) begin errors++; $display("FAIL zero_pix_busy got=%0d want=1", obs_busy); end
        run_job(0, 1, 2, 100, -1, -1, -1, -1);
        checks++; if (obs_beat != "1,") begin errors++; $display("FAIL zero_pass_beats got=%s want=%s", obs_beat, "1,"); end
        checks++; if (obs_rst != "12,") begin errors++; $display("FAIL zero_pass_rst got=%s want=%s", obs_rst, "12,"); end
        checks++; if (obs_ov != "16:0,") begin errors++; $display("FAIL zero_pass_out got=%s want=%s", obs_ov, "16:0,"); end
        checks++; if (obs_done != "17,") begin errors++; $display("FAIL zero_pass_done got=%s want=%s", obs_done, "17,"); end
    endtask

    task automatic test_abort();
        run_job(2, 3, 4, 100, -1, -1, 5, -1);
        checks++; if (obs_beat != "1,2,3,4,5,") begin errors++; $display("FAIL abort_beats got=%s want=%s", obs_beat, "1,2,3,4,5,"); end
        checks++; if (obs_bias != "1,3,5,") begin errors++; $display("FAIL abort_bias got=%s want=%s", obs_bias, "1,3,5,"); end
        checks++; if ({obs_rst, obs_ov, obs_done} != "") begin errors++; $display("FAIL abort_no_events got=%s|%s|%s want=empty", obs_rst, obs_ov, obs_done); end
        checks++; if (obs_busy !== 5) begin errors++; $display("FAIL abort_busy got=%0d want=5", obs_busy); end
        run_job(2, 2, 1, 100, -1, -1, 0, -1);
        checks++; if ({obs_beat, obs_done} != "" || obs_busy !== 0) begin errors++; $display("FAIL abort_vs_start got=%s|%s busy=%0d want=empty busy=0", obs_beat, obs_done, obs_busy); end
        run_job(3, 2, 7, 100, -1, -1, -1, -1);
        checks++; if (obs_ov != "18:0,21:1,") begin errors++; $display("FAIL abort_restart_out got=%s want=%s", obs_ov, "18:0,21:1,"); end
        checks++; if (obs_done != "22,") begin errors++; $display("FAIL abort_restart_done got=%s want=%s", obs_done, "22,"); end
    endtask

    task automatic test_start_while_busy();
        run_job(2, 2, 5, 100, -1, -1, -1, 3);
        checks++; if (obs_beat != "1,2,3,4,") begin errors++; $display("FAIL busy_start_beats got=%s want=%s", obs_beat, "1,2,3,4,"); end
        checks++; if (obs_ov != "17:0,19:1,") begin errors++; $display("FAIL busy_start_out got=%s want=%s", obs_ov, "17:0,19:1,"); end
        checks++; if (obs_done != "20,") begin errors++; $display("FAIL busy_start_done got=%s want=%s", obs_done, "20,"); end
        checks++; if (npu_scale !== 4'd5) begin errors++; $display("FAIL busy_start_scale got=%0d want=5", npu_scale); end
    endtask

    task automatic test_random();
        int p, n, ab, alt;
        for (int it = 0; it < 12; it++) begin
            p = $urandom_range(0, 4);
            n = $urandom_range(0, 5);
            ab = (it % 4 == 2) ? $urandom_range(2, 10) : -1;
            alt = (it % 4 == 1 && n > 0) ? $urandom_range(2, 6) : -1;
            run_job(p, n, $urandom_range(0, 15), 70, -1, -1, ab, alt);
            checks++; if (obs_beat != exp_beat) begin errors++; $display("FAIL rand%0d_beats got=%s want=%s", it, obs_beat, exp_beat); end
            checks++; if (obs_bias != exp_bias) begin errors++; $display("FAIL rand%0d_bias got=%s want=%s", it, obs_bias, exp_bias); end
            checks++; if (obs_rst != exp_rst) begin errors++; $display("FAIL rand%0d_rst got=%s want=%s", it, obs_rst, exp_rst); end
            checks++; if (obs_ov != exp_ov) begin errors++; $display("FAIL rand%0d_out got=%s want=%s", it, obs_ov, exp_ov); end
            checks++; if (obs_done != exp_done) begin errors++; $display("FAIL rand%0d_done got=%s want=%s", it, obs_done, exp_done); end
            checks++; if (obs_busy !== exp_busy) begin errors++; $display("FAIL rand%0d_busy got=%0d want=%0d", it, obs_busy, exp_busy); end
            checks++; if (obs_bad !== 0) begin errors++; $display("FAIL rand%0d_handshake got=%0d want=0", it, obs_bad); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_single_pass();
        test_zero_cfg();
        test_abort();
        test_start_while_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
